// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcodes, default widths and
// the instruction-memory loader state encoding.
package cpu_defs;

  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DATA_W = 16;
  localparam int IMEM_DEPTH  = 256;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JUMP = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [15:0] NOP_WORD = {OP_NOP, 12'h000};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } ld_state_t;

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: one write port, asynchronous read port.
// Contents are never reset.
module imem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // write port
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Program loader and instruction memory feeding the CPU.
// IMEM_PAD_EN: addresses at or beyond word_count read as NOP.
module imem_loader
  import cpu_defs::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_datain,
  output logic              cpu_start,
  output logic              cpu_enable,
  output logic [ADDR_W:0]   word_count,
  output logic              load_err
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] NOP_D    = DATA_W'(NOP_WORD);

  ld_state_t         state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [DATA_W-1:0] ram_q;
  logic              accept;

  assign load_ready = (state == ST_IDLE) || (state == ST_LOAD);
  assign accept     = load_valid && load_ready;

  imem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clock (clock),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (load_data),
    .raddr (i_addr),
    .rdata (ram_q)
  );

  // load FSM, write pointer and registered CPU controls
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      word_count <= '0;
      load_err   <= 1'b0;
      cpu_start  <= 1'b0;
      cpu_enable <= 1'b0;
    end else begin
      cpu_start <= 1'b0;
      unique case (state)
        ST_IDLE, ST_LOAD: begin
          if (accept) begin
            wr_ptr     <= wr_ptr + 1'b1;
            word_count <= word_count + 1'b1;
            if (load_last) begin
              state      <= ST_START;
              cpu_start  <= 1'b1;
              cpu_enable <= 1'b1;
            end else if (wr_ptr == LAST_PTR) begin
              state    <= ST_ERR;
              load_err <= 1'b1;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_START: state <= ST_RUN;
        ST_RUN:   state <= ST_RUN;
        ST_ERR:   state <= ST_ERR;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // instruction read: NOP until the program has been started
  always_comb begin
    i_datain = NOP_D;
    if (state == ST_START || state == ST_RUN) begin
      i_datain = ram_q;
`ifdef IMEM_PAD_EN
      if ({1'b0, i_addr} >= word_count) i_datain = NOP_D;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: queue-level load model checked
// every cycle, plus directed literal checks.
module tb_imem_loader;
  import cpu_defs::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic        load_last = 1'b0;
  logic [7:0]  i_addr = '0;
  logic [15:0] i_datain;
  logic        cpu_start;
  logic        cpu_enable;
  logic [8:0]  word_count;
  logic        load_err;

  int n_vec  = 0;
  int n_miss = 0;

`ifdef IMEM_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  localparam logic [15:0] W_JUMP = 16'h4021;
  localparam logic [15:0] W_HALT = 16'hF000;

  imem_loader dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .i_addr     (i_addr),
    .i_datain   (i_datain),
    .cpu_start  (cpu_start),
    .cpu_enable (cpu_enable),
    .word_count (word_count),
    .load_err   (load_err)
  );

  always #5 clock = ~clock;

  // model: program image plus "loaded / failed" flags
  logic [15:0] mm [256];
  bit          mv [256];
  int          m_cnt   = 0;
  bit          m_done  = 0;
  bit          m_err   = 0;
  bit          m_start = 0;
  bit          armed   = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_cnt   <= 0;
      m_done  <= 0;
      m_err   <= 0;
      m_start <= 0;
    end else if (load_valid && !m_done && !m_err) begin
      mm[m_cnt % 256] <= load_data;
      mv[m_cnt % 256] <= 1'b1;
      m_cnt   <= m_cnt + 1;
      m_done  <= load_last;
      m_start <= load_last;
      m_err   <= !load_last && (m_cnt == 255);
    end else begin
      m_start <= 0;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clock) begin
    if (armed && !reset) begin
      logic [15:0] ed;
      bit          dchk;
      chk("ready", 32'(load_ready), 32'(!m_done && !m_err));
      chk("start", 32'(cpu_start), 32'(m_start));
      chk("enable", 32'(cpu_enable), 32'(m_done));
      chk("err", 32'(load_err), 32'(m_err));
      chk("count", 32'(word_count), 32'(m_cnt));
      dchk = 1;
      ed   = 16'h0000;
      if (m_done) begin
        if (PAD && int'(i_addr) >= m_cnt) ed = 16'h0000;
        else if (mv[i_addr]) ed = mm[i_addr];
        else dchk = 0;
      end
      if (dchk) chk("datain", 32'(i_datain), 32'(ed));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = l;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic do_reset();
    load_valid = 1'b0;
    load_last  = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    armed = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_ready", 32'(load_ready), 32'd1);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_enable", 32'(cpu_enable), 32'd0);

    // five-word program
    send(W_JUMP, 0);
    send(16'h0000, 0);
    send(16'h0000, 0);
    send(16'h0000, 0);
    send(W_HALT, 1);
    chk("t1_start_hi", 32'(cpu_start), 32'd1);
    step();
    chk("t1_start_lo", 32'(cpu_start), 32'd0);
    chk("t1_enable", 32'(cpu_enable), 32'd1);
    chk("t1_count", 32'(word_count), 32'd5);
    i_addr = 8'd0; #1;
    chk("t1_addr0", 32'(i_datain), 32'(W_JUMP));
    i_addr = 8'd4; #1;
    chk("t1_addr4", 32'(i_datain), 32'(W_HALT));
    step();

    // gapped valid: idle cycles carry junk and load_last
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(16'hA100 + 16'(i), i == 5);
      if (i < 5) begin
        load_data = 16'hBAD0;
        load_last = 1'b1;
        step();
        load_last = 1'b0;
      end
    end
    chk("t2_count", 32'(word_count), 32'd6);
    for (int a = 0; a < 6; a++) begin
      i_addr = 8'(a); #1;
      chk("t2_word", 32'(i_datain), 32'(16'hA100 + 16'(a)));
    end
    i_addr = 8'd0;
    step();

    // overflow: 256 words, none marked last
    do_reset();
    for (int i = 0; i < 256; i++) send(16'hC000 ^ 16'(i), 0);
    chk("t3_err", 32'(load_err), 32'd1);
    chk("t3_ready", 32'(load_ready), 32'd0);
    chk("t3_enable", 32'(cpu_enable), 32'd0);
    chk("t3_count", 32'(word_count), 32'd256);
    load_valid = 1'b1;
    load_last  = 1'b1;
    repeat (3) step();
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("t3_sticky", 32'(load_err), 32'd1);

    // full program, last word marked
    do_reset();
    for (int i = 0; i < 256; i++)
      send(16'h5000 ^ 16'(i), i == 255);
    chk("t4_start", 32'(cpu_start), 32'd1);
    chk("t4_count", 32'(word_count), 32'd256);
    i_addr = 8'hFF; #1;
    chk("t4_addrff", 32'(i_datain), 32'h50FF);
    i_addr = 8'h00;
    step();

    // reset mid-load, then shorter reload
    do_reset();
    send(16'hA001, 0);
    send(16'hA002, 0);
    send(16'hA003, 0);
    reset = 1'b1;
    step();
    chk("t5_count", 32'(word_count), 32'd0);
    chk("t5_ready", 32'(load_ready), 32'd1);
    reset = 1'b0;
    send(16'hB001, 0);
    send(16'hB002, 1);
    step();
    i_addr = 8'd2; #1;
    chk("t5_addr2", 32'(i_datain),
        PAD ? 32'h0000 : 32'hA003);
    i_addr = 8'd1; #1;
    chk("t5_addr1", 32'(i_datain), 32'hB002);

    // writes ignored while running
    i_addr     = 8'd0;
    load_valid = 1'b1;
    load_data  = 16'hDEAD;
    load_last  = 1'b1;
    repeat (4) begin
      step();
      chk("t6_ready", 32'(load_ready), 32'd0);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("t6_addr0", 32'(i_datain), 32'hB001);
    chk("t6_count", 32'(word_count), 32'd2);
    chk("t6_enable", 32'(cpu_enable), 32'd1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction-memory stage directly upstream of the CPU; produces the CPU's `i_datain` from its 8-bit `pc`.
- Accepts a program over a valid/ready word stream and writes it into internal RAM.
- Then pulses CPU `start`, holds `enable`, and serves instruction words by address.
- Replaces bench-driven `i_datain` sequencing with a real loaded program image.

Parameters:
- ADDR_W, 8, address width; matches CPU `pc`/`d_addr` width.
- DATA_W, 16, instruction word width.
- DEPTH, 256, number of words; must equal 2**ADDR_W.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- load_valid  in  1  load_data/load_last valid this cycle.
- load_ready  out  1  loader accepts a word this cycle.
- load_data  in  DATA_W  program word.
- load_last  in  1  marks the final program word.
- i_addr  in  ADDR_W  CPU program counter.
- i_datain  out  DATA_W  instruction to CPU; combinational read of i_addr.
- cpu_start  out  1  one-cycle start pulse to CPU.
- cpu_enable  out  1  CPU enable.
- word_count  out  ADDR_W+1  number of words loaded, 0..DEPTH.
- load_err  out  1  overflow error, sticky until reset.

Behaviour:
- Word accepted on any rising edge where load_valid && load_ready.
- States: IDLE, LOAD, START, RUN, ERR.
  - IDLE: load_ready=1. Accept → write mem[0]; to START if load_last, else LOAD.
  - LOAD: load_ready=1. Each accept writes mem[wr_ptr] and increments wr_ptr/word_count.
    - Accept with load_last → START.
    - Accept of word DEPTH-1 without load_last → ERR.
  - START: exactly one cycle; cpu_start=1, cpu_enable=1; → RUN.
  - RUN: cpu_enable=1, load_ready=0. load_valid ignored. Stays until reset.
  - ERR: load_ready=0, load_err=1, cpu_enable=0. Stays until reset.
- Accepting word DEPTH-1 with load_last is legal (full program) → START, word_count=DEPTH.
- i_datain:
  - RUN/START: mem[i_addr], zero latency (asynchronous read).
  - IDLE/LOAD/ERR: 16'h0000 (NOP).
- Reset (any state, including mid-load):
  - state=IDLE, wr_ptr=0, word_count=0, load_err=0, cpu_start=0, cpu_enable=0, load_ready=1 (combinational from IDLE).
  - RAM contents are not cleared.
- Write and read same address in same cycle: cannot occur; reads are gated to NOP until START.
- load_last while load_valid=0: ignored.

Optional Feature:
- Macro IMEM_PAD_EN.
  - Defined: in START/RUN, i_addr >= word_count returns 16'h0000 (NOP), so unloaded or stale words are never executed.
  - Undefined: every address returns raw RAM contents, including leftovers from a previous load.

Decomposition:
- Shared package cpu_defs: opcode constants (NOP, HALT, JUMP, ...), ADDR_W/DATA_W defaults, state encoding typedef for this FSM.
- One sub-module imem_ram: single write port, asynchronous read port, no reset.
- FSM and counters stay in imem_loader.

Test Plan:
- Load 5 words {JUMP 16'h4021?, NOP, NOP, NOP, HALT} with load_last on the 5th →
  - cpu_start high for exactly 1 cycle, one cycle after the last accept;
  - word_count=5; i_addr=0 → JUMP word; i_addr=4 → HALT word.
- load_valid toggled every other cycle during LOAD → only handshaked words are stored; word_count matches accept count; no gaps in memory.
- Stream 256 words, none with load_last →
  - after the 256th accept: load_err=1, load_ready=0, cpu_enable=0, cpu_start never pulses.
- Stream 256 words, last with load_last → START entered, word_count=256, i_addr=8'hFF returns word 255.
- Assert reset after 3 of 6 words → next cycle IDLE, word_count=0, load_ready=1. Reload of 2 words →
  - with IMEM_PAD_EN: i_addr=2 reads 16'h0000;
  - without: i_addr=2 reads the stale third word.
- In RUN, drive load_valid=1 with data → load_ready=0, memory unchanged, word_count unchanged.
